// File: rtl/tff_sched_pkg.sv
// Shared types for the T-flop bank scheduler.
// State encoding and the requester-index width helper.
package tff_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        ACK   = 2'd2,
        CLEAR = 2'd3
    } state_t;

    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tff_bank_scheduler_if.sv
// Requester-side bundle of the T-flop bank scheduler.
// The master drives requests and clears; the slave returns acks.
interface tff_sched_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_mask;
    logic                  bank_clr;
    logic [NREQ-1:0]       req_ack;
    logic                  clr_done;

    modport master (
        output req_valid,
        output req_mask,
        output bank_clr,
        input  req_ack,
        input  clr_done
    );

    modport slave (
        input  req_valid,
        input  req_mask,
        input  bank_clr,
        output req_ack,
        output clr_done
    );
endinterface

// File: rtl/tff_bank.sv
// WIDTH T flip-flops built from SR flops, with a whole-bank clear.
// The toggle is expressed as s = t & ~q, r = t & q so s and r never overlap.
module tff_bank #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] t,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;

    assign s = t & ~q & ~{WIDTH{clr}};
    assign r = (t & q) | {WIDTH{clr}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= s | (q & ~r);
        end
    end

    a_no_sr_overlap : assert property (
        @(posedge clk) disable iff (rst) ((s & r) == '0)
    );
endmodule

// File: rtl/tff_bank_scheduler.sv
// Round-robin scheduler sharing one T-flop bank between NREQ requesters.
// Each transaction toggles the bank for one cycle and returns a one-cycle ack.
module tff_bank_scheduler
    import tff_sched_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    parameter  int CNTW  = 16,
    localparam int IDW   = id_w(NREQ)
) (
    input  logic             clk,
    input  logic             rst,
    tff_sched_if.slave       bus,
    output logic [IDW-1:0]   grant_id,
    output logic             busy,
    output logic [WIDTH-1:0] q,
    output logic [CNTW-1:0]  ops_cnt
);
    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [WIDTH-1:0] t;
    logic             clr;
    logic [IDW-1:0]   win;
    logic [IDW-1:0]   cand;
    logic             found;
    logic [IDW-1:0]   next_ptr;

    // First asserted request scanning upward from rr_ptr, wrapping.
    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign next_ptr = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_id     <= '0;
            bus.req_ack  <= '0;
            bus.clr_done <= 1'b0;
            busy         <= 1'b0;
            ops_cnt      <= '0;
            t            <= '0;
            clr          <= 1'b0;
        end else begin
            bus.req_ack  <= '0;
            bus.clr_done <= 1'b0;
            t            <= '0;
            clr          <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.bank_clr) begin
                        state <= CLEAR;
                        clr   <= 1'b1;
                        busy  <= 1'b1;
                    end else if (found) begin
                        state    <= APPLY;
                        grant_id <= win;
                        rr_ptr   <= next_ptr;
                        t        <= bus.req_mask[win*WIDTH +: WIDTH];
                        busy     <= 1'b1;
                    end
                end
                APPLY: begin
                    state       <= ACK;
                    bus.req_ack <= NREQ'(1) << grant_id;
                    ops_cnt     <= ops_cnt + 1'b1;
                end
                ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                CLEAR: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    bus.clr_done <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    tff_bank #(
        .WIDTH(WIDTH)
    ) u_bank (
        .clk(clk),
        .rst(rst),
        .t  (t),
        .clr(clr),
        .q  (q)
    );
endmodule

// File: tb/tb_tff_bank_scheduler.sv
// Bench for tff_bank_scheduler: directed sequences, a vector table
// and a randomized run against a queue-free arithmetic reference model.
module tb_tff_bank_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tff_sched_if #(.NREQ(4), .WIDTH(8)) bus ();
    tff_sched_if #(.NREQ(4), .WIDTH(8)) bus2 ();

    logic [1:0]  grant_id;
    logic        busy;
    logic [7:0]  q;
    logic [15:0] ops_cnt;
    logic [1:0]  grant_id2;
    logic        busy2;
    logic [7:0]  q2;
    logic [1:0]  ops_cnt2;

    tff_bank_scheduler #(.NREQ(4), .WIDTH(8), .CNTW(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .grant_id(grant_id),
        .busy    (busy),
        .q       (q),
        .ops_cnt (ops_cnt)
    );

    tff_bank_scheduler #(.NREQ(4), .WIDTH(8), .CNTW(2)) dut2 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus2),
        .grant_id(grant_id2),
        .busy    (busy2),
        .q       (q2),
        .ops_cnt (ops_cnt2)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] masks;
        logic        clr;
        logic        ev_clr;
        int          id;
        logic [7:0]  q;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.req_mask   = '0;
        bus.bank_clr   = 1'b0;
        bus2.req_valid = '0;
        bus2.req_mask  = '0;
        bus2.bank_clr  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [15:0] exp_ops;
    logic        got;
    logic [3:0]  acc;
    logic [3:0]  pv;
    logic [7:0]  mk [4];
    logic [7:0]  mq;
    int          ptr;
    int          w;
    logic        clr_now;
    int          nacks;

    initial begin
        tbl[0]  = '{4'hF, 32'h08040201, 1'b0, 1'b0, 0, 8'h01};
        tbl[1]  = '{4'hF, 32'h08040201, 1'b0, 1'b0, 1, 8'h03};
        tbl[2]  = '{4'hF, 32'h08040201, 1'b0, 1'b0, 2, 8'h07};
        tbl[3]  = '{4'hF, 32'h08040201, 1'b0, 1'b0, 3, 8'h0F};
        tbl[4]  = '{4'hF, 32'h08040201, 1'b0, 1'b0, 0, 8'h0E};
        tbl[5]  = '{4'h8, 32'h10000000, 1'b0, 1'b0, 3, 8'h1E};
        tbl[6]  = '{4'h9, 32'h10000001, 1'b0, 1'b0, 0, 8'h1F};
        tbl[7]  = '{4'h9, 32'h10000001, 1'b0, 1'b0, 3, 8'h0F};
        tbl[8]  = '{4'h1, 32'h000000AA, 1'b0, 1'b0, 0, 8'hA5};
        tbl[9]  = '{4'h2, 32'h0000FF00, 1'b1, 1'b1, 0, 8'h00};
        tbl[10] = '{4'h2, 32'h0000FF00, 1'b0, 1'b0, 1, 8'hFF};
        tbl[11] = '{4'h4, 32'h00000000, 1'b0, 1'b0, 2, 8'hFF};

        // Reset values, then reset in the middle of an APPLY cycle.
        do_reset();
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_grant", 32'(grant_id), 32'h0);
        chk("rst_ops", 32'(ops_cnt), 32'h0);
        chk("rst_ack", 32'(bus.req_ack), 32'h0);
        chk("rst_clrdone", 32'(bus.clr_done), 32'h0);
        bus.req_valid = 4'h1;
        bus.req_mask  = 32'h000000FF;
        tick();
        chk("t1_busy_apply", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("t1_q", 32'(q), 32'h0);
        chk("t1_busy", 32'(busy), 32'h0);
        chk("t1_ops", 32'(ops_cnt), 32'h0);
        chk("t1_ack", 32'(bus.req_ack), 32'h0);
        bus.req_valid = '0;
        tick();
        rst = 1'b0;
        acc = '0;
        for (int c = 0; c < 4; c++) begin
            tick();
            acc |= bus.req_ack;
        end
        chk("t1_no_ack", 32'(acc), 32'h0);
        chk("t1_q_after", 32'(q), 32'h0);

        // Single request twice, exact two-cycle latency.
        for (int r = 0; r < 2; r++) begin
            bus.req_valid = 4'h1;
            bus.req_mask  = 32'h0000000F;
            tick();
            chk("t2_ack_early", 32'(bus.req_ack), 32'h0);
            tick();
            chk("t2_ack", 32'(bus.req_ack), 32'h1);
            chk("t2_q", 32'(q), (r == 0) ? 32'h0F : 32'h00);
            bus.req_valid = '0;
            tick();
            chk("t2_ack_pulse", 32'(bus.req_ack), 32'h0);
            chk("t2_ops", 32'(ops_cnt), 32'(r + 1));
        end

        // Vector table: round robin, pointer wrap, clear priority, zero mask.
        do_reset();
        exp_ops = '0;
        for (int v = 0; v < 12; v++) begin
            bus.req_valid = tbl[v].valid;
            bus.req_mask  = tbl[v].masks;
            bus.bank_clr  = tbl[v].clr;
            got = 1'b0;
            for (int c = 0; c < 8 && !got; c++) begin
                tick();
                if (bus.req_ack != '0 || bus.clr_done) got = 1'b1;
            end
            chk($sformatf("tbl%0d_event", v), 32'(got), 32'h1);
            if (got) begin
                chk($sformatf("tbl%0d_q", v), 32'(q), 32'(tbl[v].q));
                if (tbl[v].ev_clr) begin
                    chk($sformatf("tbl%0d_clrdone", v), 32'(bus.clr_done), 32'h1);
                    chk($sformatf("tbl%0d_ack", v), 32'(bus.req_ack), 32'h0);
                    bus.bank_clr = 1'b0;
                end else begin
                    chk($sformatf("tbl%0d_ack", v), 32'(bus.req_ack),
                        32'(1) << tbl[v].id);
                    chk($sformatf("tbl%0d_grant", v), 32'(grant_id),
                        32'(tbl[v].id));
                    exp_ops++;
                    bus.req_valid = bus.req_valid & ~bus.req_ack;
                    tick();
                    chk($sformatf("tbl%0d_ops", v), 32'(ops_cnt), 32'(exp_ops));
                    chk($sformatf("tbl%0d_idle", v), 32'(busy), 32'h0);
                end
            end
        end
        bus.req_valid = '0;
        bus.bank_clr  = 1'b0;

        // Narrow counter: five zero-mask requests wrap a 2-bit count to 1.
        do_reset();
        nacks = 0;
        for (int n = 0; n < 5; n++) begin
            bus2.req_valid = 4'h1;
            bus2.req_mask  = '0;
            got = 1'b0;
            for (int c = 0; c < 8 && !got; c++) begin
                tick();
                if (bus2.req_ack == 4'h1) got = 1'b1;
            end
            if (got) nacks++;
            bus2.req_valid = '0;
            tick();
        end
        chk("t6_acks", 32'(nacks), 32'd5);
        chk("t6_ops_wrap", 32'(ops_cnt2), 32'h1);
        chk("t6_q", 32'(q2), 32'h0);
        chk("t6_busy", 32'(busy2), 32'h0);

        // Randomized run with pending requests held until their ack.
        do_reset();
        mq      = '0;
        ptr     = 0;
        exp_ops = '0;
        pv      = '0;
        for (int i = 0; i < 4; i++) mk[i] = '0;
        for (int it = 0; it < 300; it++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pv[i] && $urandom_range(0, 9) < 3) begin
                    pv[i] = 1'b1;
                    mk[i] = 8'($urandom);
                end
            end
            clr_now = ($urandom_range(0, 9) == 0);
            bus.req_valid = pv;
            for (int i = 0; i < 4; i++) bus.req_mask[i*8 +: 8] = mk[i];
            bus.bank_clr = clr_now;
            if (clr_now) begin
                tick();
                chk("rnd_clr_busy", 32'(busy), 32'h1);
                tick();
                mq = '0;
                chk("rnd_clr_done", 32'(bus.clr_done), 32'h1);
                chk("rnd_clr_q", 32'(q), 32'(mq));
                chk("rnd_clr_noack", 32'(bus.req_ack), 32'h0);
                bus.bank_clr = 1'b0;
            end else if (pv != '0) begin
                w = -1;
                for (int k = 0; k < 4; k++) begin
                    if (w < 0 && pv[(ptr + k) % 4]) w = (ptr + k) % 4;
                end
                mq      = mq ^ mk[w];
                ptr     = (w + 1) % 4;
                exp_ops = exp_ops + 16'd1;
                tick();
                chk("rnd_busy", 32'(busy), 32'h1);
                chk("rnd_ack_early", 32'(bus.req_ack), 32'h0);
                tick();
                chk("rnd_ack", 32'(bus.req_ack), 32'(1) << w);
                chk("rnd_grant", 32'(grant_id), 32'(w));
                chk("rnd_q", 32'(q), 32'(mq));
                pv[w] = 1'b0;
                bus.req_valid = pv;
                tick();
                chk("rnd_ops", 32'(ops_cnt), 32'(exp_ops));
                chk("rnd_idle", 32'(busy), 32'h0);
                chk("rnd_ack_pulse", 32'(bus.req_ack), 32'h0);
            end else begin
                tick();
                chk("rnd_quiet_busy", 32'(busy), 32'h0);
                chk("rnd_quiet_q", 32'(q), 32'(mq));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
